vga_sync_gen: RTL and testbench



---
 rtl/vga_sync_gen.sv | 102 ++++++++++
 tb/tb_vga_sync_gen.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/vga_sync_gen.sv
// Raster timing generator: pixel-rate enable, x/y scan counters, registered sync/blank decode.
// Optional frame counter enabled by defining VGA_FRAME_CNT_EN.
module vga_sync_gen #(
  parameter int unsigned H_DISPLAY = 640,
  parameter int unsigned H_FRONT   = 16,
  parameter int unsigned H_SYNC    = 96,
  parameter int unsigned H_BACK    = 48,
  parameter int unsigned V_DISPLAY = 480,
  parameter int unsigned V_FRONT   = 10,
  parameter int unsigned V_SYNC    = 2,
  parameter int unsigned V_BACK    = 33,
  parameter int unsigned TICK_DIV  = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        p_tick,
  output logic [9:0]  x,
  output logic [9:0]  y,
  output logic        video_on,
  output logic        hsync,
  output logic        vsync,
  output logic        frame_start,
  output logic [15:0] frame_cnt
);

  localparam int unsigned H_TOTAL  = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned V_TOTAL  = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
  localparam int unsigned HS_START = H_DISPLAY + H_FRONT;
  localparam int unsigned HS_END   = HS_START + H_SYNC - 1;
  localparam int unsigned VS_START = V_DISPLAY + V_FRONT;
  localparam int unsigned VS_END   = VS_START + V_SYNC - 1;
  localparam int unsigned DivW     = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_bad_total
    $fatal(1, "vga_sync_gen: H_TOTAL and V_TOTAL must fit 10-bit counters");
  end
  if (TICK_DIV < 1) begin : g_bad_div
    $fatal(1, "vga_sync_gen: TICK_DIV must be >= 1");
  end

  logic [DivW-1:0] div_q, div_d;
  logic [9:0]      x_d, y_d;
  logic            video_on_d, hsync_d, vsync_d;
  logic            start_d, start_q;

  assign p_tick = (div_q == DivW'(TICK_DIV - 1));

  always_comb begin
    div_d = p_tick ? '0 : div_q + 1'b1;
    x_d   = x;
    y_d   = y;
    if (p_tick) begin
      if (x == 10'(H_TOTAL - 1)) begin
        x_d = '0;
        y_d = (y == 10'(V_TOTAL - 1)) ? '0 : y + 10'd1;
      end else begin
        x_d = x + 10'd1;
      end
    end
    // Decode the pixel about to be loaded so all outputs describe the same pixel.
    video_on_d = (x_d < 10'(H_DISPLAY)) && (y_d < 10'(V_DISPLAY));
    hsync_d    = !((x_d >= 10'(HS_START)) && (x_d <= 10'(HS_END)));
    vsync_d    = !((y_d >= 10'(VS_START)) && (y_d <= 10'(VS_END)));
    start_d    = p_tick && (x_d == '0) && (y_d == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q       <= '0;
      x           <= 10'(H_TOTAL - 1);
      y           <= 10'(V_TOTAL - 1);
      video_on    <= 1'b0;
      hsync       <= 1'b1;
      vsync       <= 1'b1;
      start_q     <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      div_q       <= div_d;
      x           <= x_d;
      y           <= y_d;
      video_on    <= video_on_d;
      hsync       <= hsync_d;
      vsync       <= vsync_d;
      // Pulse lands in the clk after the edge that loads (0,0).
      start_q     <= start_d;
      frame_start <= start_q;
    end
  end

`ifdef VGA_FRAME_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_cnt <= '0;
    end else if (frame_start) begin
      frame_cnt <= frame_cnt + 16'd1;
    end
  end
`else
  assign frame_cnt = '0;
`endif

endmodule

// File: tb/tb_vga_sync_gen.sv
// Self-checking bench for vga_sync_gen: closed-form raster model feeds a scoreboard queue;
// three instances cover default timing, TICK_DIV=1 small raster and TICK_DIV=3 small raster.
module tb_vga_sync_gen;

  typedef struct packed {
    logic        p_tick;
    logic [9:0]  x;
    logic [9:0]  y;
    logic        video_on;
    logic        hsync;
    logic        vsync;
    logic        frame_start;
    logic [15:0] frame_cnt;
  } snap_t;

  // hd, hf, hs, hb, vd, vf, vs, vb, td per instance
  int P [3][9] = '{'{640, 16, 96, 48, 480, 10, 2, 33, 4},
                   '{8, 2, 2, 2, 4, 1, 1, 1, 1},
                   '{8, 2, 2, 2, 4, 1, 1, 1, 3}};

  logic clk = 1'b0;
  logic rst_a, rst_b, rst_c;
  snap_t so [3];
  snap_t sb_q [$];
  int k [3];
  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  vga_sync_gen u_a (
    .clk(clk), .rst_n(rst_a), .p_tick(so[0].p_tick), .x(so[0].x), .y(so[0].y),
    .video_on(so[0].video_on), .hsync(so[0].hsync), .vsync(so[0].vsync),
    .frame_start(so[0].frame_start), .frame_cnt(so[0].frame_cnt)
  );

  vga_sync_gen #(
    .H_DISPLAY(8), .H_FRONT(2), .H_SYNC(2), .H_BACK(2),
    .V_DISPLAY(4), .V_FRONT(1), .V_SYNC(1), .V_BACK(1), .TICK_DIV(1)
  ) u_b (
    .clk(clk), .rst_n(rst_b), .p_tick(so[1].p_tick), .x(so[1].x), .y(so[1].y),
    .video_on(so[1].video_on), .hsync(so[1].hsync), .vsync(so[1].vsync),
    .frame_start(so[1].frame_start), .frame_cnt(so[1].frame_cnt)
  );

  vga_sync_gen #(
    .H_DISPLAY(8), .H_FRONT(2), .H_SYNC(2), .H_BACK(2),
    .V_DISPLAY(4), .V_FRONT(1), .V_SYNC(1), .V_BACK(1), .TICK_DIV(3)
  ) u_c (
    .clk(clk), .rst_n(rst_c), .p_tick(so[2].p_tick), .x(so[2].x), .y(so[2].y),
    .video_on(so[2].video_on), .hsync(so[2].hsync), .vsync(so[2].vsync),
    .frame_start(so[2].frame_start), .frame_cnt(so[2].frame_cnt)
  );

  // Expected outputs after kk rising edges since reset release (kk=0: in reset).
  function automatic snap_t model(int id, int kk);
    snap_t e;
    int hd = P[id][0], hf = P[id][1], hs = P[id][2], hb = P[id][3];
    int vd = P[id][4], vf = P[id][5], vs = P[id][6], vb = P[id][7], td = P[id][8];
    int h_tot = hd + hf + hs + hb;
    int v_tot = vd + vf + vs + vb;
    int f = h_tot * v_tot;
    int t, q, xx, yy, j, tt;
    e.p_tick = ((kk % td) == td - 1);
    t = kk / td;
    if (t == 0) begin
      xx = h_tot - 1;
      yy = v_tot - 1;
    end else begin
      q  = (t - 1) % f;
      xx = q % h_tot;
      yy = q / h_tot;
    end
    e.x        = 10'(xx);
    e.y        = 10'(yy);
    e.video_on = (xx < hd) && (yy < vd);
    e.hsync    = !((xx >= hd + hf) && (xx <= hd + hf + hs - 1));
    e.vsync    = !((yy >= vd + vf) && (yy <= vd + vf + vs - 1));
    j = kk - 1;
    e.frame_start = (j >= td) && ((j % td) == 0) && ((((j / td) - 1) % f) == 0);
    e.frame_cnt = '0;
`ifdef VGA_FRAME_CNT_EN
    if (kk >= 2) begin
      tt = (kk - 2) / td;
      if (tt >= 1) e.frame_cnt = 16'(((tt - 1) / f) + 1);
    end
`endif
    return e;
  endfunction

  function automatic logic rst_of(int id);
    case (id)
      0: return rst_a;
      1: return rst_b;
      default: return rst_c;
    endcase
  endfunction

  task automatic set_rst(input int id, input logic v);
    case (id)
      0: rst_a = v;
      1: rst_b = v;
      default: rst_c = v;
    endcase
  endtask

  task automatic compare(input int id);
    snap_t e = sb_q.pop_front();
    snap_t o = so[id];
    total++;
    assert (o === e) else begin
      bad++;
      $error("FAIL dut%0d k=%0d observed=%h (x=%0d y=%0d) expected=%h (x=%0d y=%0d)",
             id, k[id], o, o.x, o.y, e, e.x, e.y);
    end
  endtask

  task automatic check_int(input string tag, input int o, input int e);
    total++;
    assert (o === e) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, o, e);
    end
  endtask

  task automatic step(input int id);
    @(posedge clk);
    if (rst_of(id)) k[id]++;
    sb_q.push_back(model(id, k[id]));
    #1 compare(id);
  endtask

  // Assert reset between edges and check it takes effect before the next edge.
  task automatic async_reset(input int id);
    #2 set_rst(id, 1'b0);
    k[id] = 0;
    #1 sb_q.push_back(model(id, 0));
    compare(id);
  endtask

  initial begin
    int hlow, vlow, last_fs;
    bit found;
    rst_a = 1'b0;
    rst_b = 1'b0;
    rst_c = 1'b0;
    k = '{0, 0, 0};

    // Default timing: reset, first pixel, two lines, hsync width.
    repeat (10) step(0);
    rst_a = 1'b1;
    hlow = 0;
    repeat (6500) begin
      step(0);
      if (so[0].y == 10'd0 && so[0].hsync == 1'b0) hlow++;
    end
    check_int("hsync_low_clks", hlow, 384);
    found = 1'b0;
    for (int i = 0; i < 4000 && !found; i++) begin
      step(0);
      if (so[0].x == 10'd700) found = 1'b1;
    end
    check_int("seek_a_x700", int'(found), 1);
    check_int("hsync_low_at_700", int'(so[0].hsync), 0);
    async_reset(0);
    repeat (3) step(0);
    rst_a = 1'b1;
    repeat (20) step(0);

    // TICK_DIV=1 small raster: frame period and mid-frame reset during vsync.
    repeat (5) step(1);
    rst_b = 1'b1;
    last_fs = -1;
    repeat (3 * 98 + 10) begin
      step(1);
      if (so[1].frame_start) begin
        if (last_fs >= 0) check_int("frame_period_b", k[1] - last_fs, 98);
        last_fs = k[1];
      end
    end
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      step(1);
      if (so[1].x == 10'd11 && so[1].y == 10'd5) found = 1'b1;
    end
    check_int("seek_b_x11y5", int'(found), 1);
    check_int("sync_low_b", int'({so[1].hsync, so[1].vsync}), 0);
    async_reset(1);
    repeat (2) step(1);
    rst_b = 1'b1;
    repeat (30) step(1);

    // TICK_DIV=3 small raster: vsync width over the first frame, three frames.
    repeat (5) step(2);
    rst_c = 1'b1;
    vlow = 0;
    repeat (3 * 294 + 10) begin
      step(2);
      if (k[2] <= 294 && so[2].vsync == 1'b0) vlow++;
    end
    check_int("vsync_low_clks_c", vlow, 42);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
